// File: rtl/fsw_dec_pkg.sv
// Shared definitions for the switching-frequency decoder.
//   code_t    : 3-bit frequency code (000 = 200 kHz ... 111 = 1.5625 kHz)
//   state_t   : measurement FSM states
//   P0_DEF    : default Clk cycles per Fsw period for code 000
//   CNT_W_DEF : default period counter width
//   thr(k,p0) : upper period bound of code k, 1.5 * p0 * 2^k
package fsw_dec_pkg;

  typedef logic [2:0] code_t;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam int unsigned P0_DEF    = 500;
  localparam int unsigned CNT_W_DEF = 17;

  // Geometric midpoint-ish boundary between code k and code k+1.
  function automatic int unsigned thr(input int unsigned k, input int unsigned p0 = P0_DEF);
    return (3 * p0 * (32'd1 << k)) / 2;
  endfunction

endpackage

// File: rtl/fsw_freq_decoder_if.sv
// Bundle between the Fsw source, the decoder and its consumers.
//   Fsw      : switching waveform into the decoder (asynchronous to Clk)
//   Selector : decoded frequency code
//   Valid    : Selector reflects a confirmed measurement
//   Update   : one-cycle pulse when Selector/Valid is written
//   Err      : last measured period out of range (sticky until next in-range period)
//   Period   : last measured period in Clk cycles
//   NoSig    : only when FSW_DEC_TIMEOUT_EN is defined; no Fsw edge for T7 cycles
// Modports: master = decoder side, slave = source/consumer side.
interface fsw_freq_decoder_if
  import fsw_dec_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             Fsw;
  code_t            Selector;
  logic             Valid;
  logic             Update;
  logic             Err;
  logic [CNT_W-1:0] Period;
`ifdef FSW_DEC_TIMEOUT_EN
  logic             NoSig;

  modport master (
    input  Fsw,
    output Selector, Valid, Update, Err, Period, NoSig
  );

  modport slave (
    output Fsw,
    input  Selector, Valid, Update, Err, Period, NoSig
  );
`else
  modport master (
    input  Fsw,
    output Selector, Valid, Update, Err, Period
  );

  modport slave (
    output Fsw,
    input  Selector, Valid, Update, Err, Period
  );
`endif

endinterface

// File: rtl/fsw_sync_edge.sv
// Two-flop synchronizer for the asynchronous Fsw input followed by a registered
// rising-edge detector. o_edge is high for exactly one cycle, three Clk cycles
// after Fsw rises.
//   Clk    : system clock
//   Reset  : synchronous, active-high
//   i_fsw  : raw switching waveform
//   o_edge : one-cycle rising-edge pulse
module fsw_sync_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic i_fsw,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_edge;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= i_fsw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= r_sync2 & ~r_prev;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/fsw_freq_decoder.sv
// Measures the period of the selected Fsw square wave and decodes it back to the
// 3-bit frequency code (code k nominal period = P0 * 2^k Clk cycles). A code is
// only confirmed after two consecutive periods decode to the same code.
//   Clk   : system clock, all logic rising-edge
//   Reset : synchronous, active-high
//   bus   : fsw_freq_decoder_if.master (Fsw in; Selector/Valid/Update/Err/Period out)
// Optional: define FSW_DEC_TIMEOUT_EN to add NoSig loss-of-signal detection; when
// undefined the counter simply saturates and the next edge reports Err.
module fsw_freq_decoder
  import fsw_dec_pkg::*;
#(
  parameter int unsigned P0    = P0_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic                 Clk,
  input logic                 Reset,
  fsw_freq_decoder_if.master  bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] TLow   = CNT_W'(3 * P0 / 4);
  localparam logic [CNT_W-1:0] THigh  = CNT_W'(thr(7, P0));

  logic w_edge;

  state_t           r_state,    w_state_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic [CNT_W-1:0] r_period,   w_period_nxt;
  code_t            r_sel,      w_sel_nxt;
  logic             r_valid,    w_valid_nxt;
  logic             r_update,   w_update_nxt;
  logic             r_err,      w_err_nxt;
  code_t            r_cand,     w_cand_nxt;
  logic             r_cand_vld, w_cand_vld_nxt;
`ifdef FSW_DEC_TIMEOUT_EN
  logic             r_nosig,    w_nosig_nxt;
`endif

  code_t w_code;
  logic  w_in_range;

  fsw_sync_edge u_sync_edge (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_fsw  (bus.Fsw),
    .o_edge (w_edge)
  );

  // Classifier: smallest k with r_cnt < thr(k); anything at or above thr(7)
  // or below 0.75*P0 is out of range.
  always_comb begin
    w_code     = code_t'(7);
    w_in_range = 1'b0;
    if (r_cnt >= TLow && r_cnt < THigh) begin
      w_in_range = 1'b1;
      for (int k = 6; k >= 0; k--) begin
        if (r_cnt < CNT_W'(thr(unsigned'(k), P0))) begin
          w_code = code_t'(k);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_period_nxt   = r_period;
    w_sel_nxt      = r_sel;
    w_valid_nxt    = r_valid;
    w_update_nxt   = 1'b0;
    w_err_nxt      = r_err;
    w_cand_nxt     = r_cand;
    w_cand_vld_nxt = r_cand_vld;
`ifdef FSW_DEC_TIMEOUT_EN
    w_nosig_nxt    = r_nosig;
`endif

    unique case (r_state)
      IDLE: begin
        // First edge only starts the clock; there is no period to measure yet.
        if (w_edge) begin
          w_state_nxt = MEAS;
          w_cnt_nxt   = CntOne;
`ifdef FSW_DEC_TIMEOUT_EN
          w_nosig_nxt = 1'b0;
`endif
        end
      end

      MEAS: begin
        if (r_cnt != CntMax) begin
          w_cnt_nxt = r_cnt + CntOne;
        end
        if (w_edge) begin
          w_period_nxt = r_cnt;
          w_cnt_nxt    = CntOne;
          if (!w_in_range) begin
            w_err_nxt      = 1'b1;
            w_cand_vld_nxt = 1'b0;
            w_cand_nxt     = '0;
          end else begin
            w_err_nxt = 1'b0;
            // Confirm only on the second matching period, and only announce changes.
            if (r_cand_vld && (r_cand == w_code) && ((w_code != r_sel) || !r_valid)) begin
              w_sel_nxt    = w_code;
              w_valid_nxt  = 1'b1;
              w_update_nxt = 1'b1;
            end
            w_cand_nxt     = w_code;
            w_cand_vld_nxt = 1'b1;
          end
        end
`ifdef FSW_DEC_TIMEOUT_EN
        else if (r_cnt >= THigh) begin
          // Waveform gone: drop the lock and wait for a fresh first edge.
          w_nosig_nxt    = 1'b1;
          w_valid_nxt    = 1'b0;
          w_update_nxt   = 1'b1;
          w_cand_vld_nxt = 1'b0;
          w_cand_nxt     = '0;
          w_cnt_nxt      = '0;
          w_state_nxt    = IDLE;
        end
`endif
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_period   <= '0;
      r_sel      <= '0;
      r_valid    <= 1'b0;
      r_update   <= 1'b0;
      r_err      <= 1'b0;
      r_cand     <= '0;
      r_cand_vld <= 1'b0;
`ifdef FSW_DEC_TIMEOUT_EN
      r_nosig    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_period   <= w_period_nxt;
      r_sel      <= w_sel_nxt;
      r_valid    <= w_valid_nxt;
      r_update   <= w_update_nxt;
      r_err      <= w_err_nxt;
      r_cand     <= w_cand_nxt;
      r_cand_vld <= w_cand_vld_nxt;
`ifdef FSW_DEC_TIMEOUT_EN
      r_nosig    <= w_nosig_nxt;
`endif
    end
  end

  assign bus.Selector = r_sel;
  assign bus.Valid    = r_valid;
  assign bus.Update   = r_update;
  assign bus.Err      = r_err;
  assign bus.Period   = r_period;
`ifdef FSW_DEC_TIMEOUT_EN
  assign bus.NoSig    = r_nosig;
`endif

endmodule

// File: tb/tb_fsw_freq_decoder.sv
// Bench for fsw_freq_decoder. Runs with a scaled P0 (50) so every code, including
// 111 and the loss-of-signal timeout, fits in a short simulation. Fsw is driven on
// the falling Clk edge; outputs are sampled on falling edges.
module tb_fsw_freq_decoder;

  localparam int P0    = 50;
  localparam int CNT_W = 17;
  localparam int T7    = 3 * P0 * 128 / 2;
  localparam int ChkAt = 8;

  logic Clk;
  logic Reset;

  fsw_freq_decoder_if #(.CNT_W(CNT_W)) bus ();

  fsw_freq_decoder #(
    .P0    (P0),
    .CNT_W (CNT_W)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;
  int upd_seen = 0;

  always @(negedge Clk) begin
    if (bus.Update === 1'b1) upd_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference model, one step per Fsw rising edge.
  int m_sel, m_valid, m_err, m_period, m_upd, m_nosig, m_cand, m_candv, m_armed;
  int last_p = 0;

  function automatic int tb_thr(input int k);
    return 3 * P0 * (1 << k) / 2;
  endfunction

  function automatic int classify(input int p);
    if (4 * p < 3 * P0) return -1;
    for (int k = 0; k < 8; k++) begin
      if (p < tb_thr(k)) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_valid = 0; m_err = 0; m_period = 0;
    m_nosig = 0; m_cand = 0; m_candv = 0; m_armed = 0;
  endtask

  task automatic model_edge(input int gap);
    int c;
`ifdef FSW_DEC_TIMEOUT_EN
    if (m_armed != 0 && gap > T7) begin
      m_valid = 0; m_nosig = 1; m_upd++; m_candv = 0; m_armed = 0;
    end
`endif
    if (m_armed == 0) begin
      m_armed = 1;
      m_nosig = 0;
    end else begin
      c = classify(gap);
      m_period = gap;
      if (c < 0) begin
        m_err = 1;
        m_candv = 0;
      end else begin
        m_err = 0;
        if (m_candv != 0 && m_cand == c && (c != m_sel || m_valid == 0)) begin
          m_sel = c; m_valid = 1; m_upd++;
        end
        m_cand = c;
        m_candv = 1;
      end
    end
  endtask

  int s_sel, s_valid, s_err, s_period, s_upd, s_upd_at, s_nosig;

  task automatic sample_and_check();
    model_edge(last_p);
    s_sel    = int'(bus.Selector);
    s_valid  = int'(bus.Valid);
    s_err    = int'(bus.Err);
    s_period = int'(bus.Period);
    s_upd    = upd_seen;
`ifdef FSW_DEC_TIMEOUT_EN
    s_nosig  = int'(bus.NoSig);
    chk("model_nosig", s_nosig, m_nosig);
`else
    s_nosig  = 0;
`endif
    chk("model_sel", s_sel, m_sel);
    chk("model_valid", s_valid, m_valid);
    chk("model_err", s_err, m_err);
    chk("model_period", s_period, m_period);
    chk("model_updates", s_upd, m_upd);
  endtask

  // One Fsw period of p cycles starting with a rising edge; checks just after the edge.
  task automatic fsw_cycle(input int p);
    s_upd_at = -1;
    for (int i = 0; i < p; i++) begin
      if (bus.Update === 1'b1 && s_upd_at < 0) s_upd_at = i;
      if (i == 0) bus.Fsw = 1'b1;
      if (i == p / 2) bus.Fsw = 1'b0;
      if (i == ChkAt) sample_and_check();
      @(negedge Clk);
    end
    last_p = p;
  endtask

  typedef struct {
    int p;
    int sel;
    int valid;
    int err;
    int period;
    int upd;
    int upd_at;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int first;
    int r, p, k, k_prev;

    // Each row: period driven, then outputs expected just after that period's rising
    // edge (which closes the previous row's period).
    tbl[0]  = '{400,  0, 0, 0, 0,    0, -1};
    tbl[1]  = '{400,  0, 0, 0, 400,  0, -1};
    tbl[2]  = '{400,  3, 1, 0, 400,  1,  4};
    tbl[3]  = '{50,   3, 1, 0, 400,  1, -1};
    tbl[4]  = '{50,   3, 1, 0, 50,   1, -1};
    tbl[5]  = '{6400, 0, 1, 0, 50,   2,  4};
    tbl[6]  = '{6400, 0, 1, 0, 6400, 2, -1};
    tbl[7]  = '{30,   7, 1, 0, 6400, 3,  4};
    tbl[8]  = '{100,  7, 1, 1, 30,   3, -1};
    tbl[9]  = '{100,  7, 1, 0, 100,  3, -1};
    tbl[10] = '{200,  1, 1, 0, 100,  4,  4};
    tbl[11] = '{600,  1, 1, 0, 200,  4, -1};
    tbl[12] = '{200,  1, 1, 0, 600,  4, -1};
    tbl[13] = '{600,  1, 1, 0, 200,  4, -1};
    tbl[14] = '{200,  1, 1, 0, 600,  4, -1};
    tbl[15] = '{600,  1, 1, 0, 200,  4, -1};

    m_upd = 0;
    model_reset();
    Reset = 1'b1;
    bus.Fsw = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    chk("reset_sel", int'(bus.Selector), 0);
    chk("reset_valid", int'(bus.Valid), 0);
    chk("reset_err", int'(bus.Err), 0);
    chk("reset_period", int'(bus.Period), 0);
    chk("reset_update", int'(bus.Update), 0);
`ifdef FSW_DEC_TIMEOUT_EN
    chk("reset_nosig", int'(bus.NoSig), 0);
`endif

    // Directed table: lock on 8*P0, switch 000 -> 111, out of range, alternating codes.
    for (int i = 0; i < 16; i++) begin
      fsw_cycle(tbl[i].p);
      chk($sformatf("tbl%0d_sel", i), s_sel, tbl[i].sel);
      chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_err", i), s_err, tbl[i].err);
      chk($sformatf("tbl%0d_period", i), s_period, tbl[i].period);
      chk($sformatf("tbl%0d_updates", i), s_upd, tbl[i].upd);
      chk($sformatf("tbl%0d_update_cycle", i), s_upd_at, tbl[i].upd_at);
    end

    // Below range then above range, then relock on code 001.
    fsw_cycle(30);
    fsw_cycle(10000);
    chk("low_err", s_err, 1);
    chk("low_sel_held", s_sel, 1);
    fsw_cycle(100);
`ifndef FSW_DEC_TIMEOUT_EN
    chk("high_err", s_err, 1);
    chk("high_valid_held", s_valid, 1);
    chk("high_period", s_period, 10000);
`endif
    fsw_cycle(100);
    fsw_cycle(100);
    chk("relock_err", s_err, 0);
    chk("relock_sel", s_sel, 1);

    // Reset mid-measurement while a candidate is held (Fsw low at reset).
    fsw_cycle(400);
    fsw_cycle(400);
    for (int i = 0; i < 400; i++) begin
      if (i == 0) bus.Fsw = 1'b1;
      if (i == 200) bus.Fsw = 1'b0;
      if (i == ChkAt) sample_and_check();
      if (i == 250) Reset = 1'b1;
      if (i == 252) Reset = 1'b0;
      if (i == 254) begin
        model_reset();
        chk("midreset_sel", int'(bus.Selector), 0);
        chk("midreset_valid", int'(bus.Valid), 0);
        chk("midreset_err", int'(bus.Err), 0);
        chk("midreset_period", int'(bus.Period), 0);
        chk("midreset_updates", upd_seen, m_upd);
      end
      @(negedge Clk);
    end
    last_p = 400;
    fsw_cycle(400);
    fsw_cycle(400);
    chk("midreset_no_relock_yet", s_valid, 0);
    fsw_cycle(400);
    chk("midreset_relock_sel", s_sel, 3);

    // Randomized periods: mostly repeated codes with jitter, some boundaries, some too short.
    k_prev = 0;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        p = int'($urandom_range(10, 30));
      end else if (r == 1) begin
        k = int'($urandom_range(0, 6));
        p = tb_thr(k) - int'($urandom_range(0, 1));
      end else begin
        k = (r < 6) ? k_prev : int'($urandom_range(0, 4));
        k_prev = k;
        p = ((P0 << k) * (85 + int'($urandom_range(0, 30)))) / 100;
      end
      fsw_cycle(p);
    end

`ifdef FSW_DEC_TIMEOUT_EN
    // Lock, then let Fsw die and time the loss-of-signal indication.
    fsw_cycle(400);
    fsw_cycle(400);
    fsw_cycle(400);
    first = -1;
    for (int i = 0; i < T7 + 20; i++) begin
      if (bus.NoSig === 1'b1 && first < 0) first = i;
      if (i == 0) bus.Fsw = 1'b1;
      if (i == ChkAt) sample_and_check();
      if (i == 200) bus.Fsw = 1'b0;
      @(negedge Clk);
    end
    n_chk++;
    if (first < T7 || first > T7 + 8) begin
      n_fail++;
      $display("FAIL nosig_delay: got %0d cycles, required %0d..%0d", first, T7, T7 + 8);
    end
    m_valid = 0; m_nosig = 1; m_upd++; m_candv = 0; m_armed = 0;
    last_p = 0;
    chk("timeout_valid", int'(bus.Valid), 0);
    chk("timeout_nosig", int'(bus.NoSig), 1);
    chk("timeout_updates", upd_seen, m_upd);
    fsw_cycle(400);
    chk("restart_nosig", s_nosig, 0);
    fsw_cycle(400);
    chk("restart_not_locked", s_valid, 0);
    fsw_cycle(400);
    chk("restart_locked", s_valid, 1);
`else
    first = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
